iir_tap_loader: RTL and testbench

- Configuration-side driver for the IIR filter's tap-programming interface.
- Holds shadow copies of the b and a coefficient sets, written over a simple register write port.
- On a commit pulse it disables the filter (which clears its history), re-enables it, then streams all b and a taps over the valid/ready channels until the filter reports done.
- Sits between the CSR decode and the filter instance.

---
 rtl/iir_pkg.sv | 18 +
 rtl/iir_tap_stream_ch.sv | 56 +++++
 rtl/iir_tap_loader.sv | 165 ++++++++++++++++
 tb/tb_iir_tap_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types for the IIR tap loader.
//   float_t        : IEEE-754 single-precision coefficient word (bits only, no arithmetic)
//   FP_ONE         : 1.0f, the reset value of shadow b[0]
//   loader_state_e : load sequencer states
package iir_pkg;

  typedef logic [31:0] float_t;

  localparam float_t FP_ONE = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_STREAM,
    ST_WAIT_DONE
  } loader_state_e;

endpackage

// File: rtl/iir_tap_stream_ch.sv
// One tap channel: walks a coefficient set over a valid/ready link.
//   clk_i, rst_n_i : clock, async active-low reset
//   start_i        : one-cycle pulse, restarts the channel at tap 0
//   coef_i         : coefficient set, stable while the channel runs
//   ready_i        : sink accepts the current beat
//   data_o         : current tap (0 when no beat is offered)
//   valid_o        : beat offered (registered, independent of ready_i)
//   exhausted_o    : every tap of the set has been accepted
module iir_tap_stream_ch
  import iir_pkg::*;
#(
  parameter int G_DEGREE = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  float_t [G_DEGREE-1:0] coef_i,
  input  logic                  ready_i,
  output float_t                data_o,
  output logic                  valid_o,
  output logic                  exhausted_o
);

  localparam int IW = (G_DEGREE > 1) ? $clog2(G_DEGREE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(G_DEGREE - 1);

  logic [IW-1:0] idx_q;
  logic          valid_q;
  logic          exh_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      exh_q   <= 1'b0;
    end else if (start_i) begin
      idx_q   <= '0;
      valid_q <= 1'b1;
      exh_q   <= 1'b0;
    end else if (valid_q && ready_i) begin
      if (idx_q == LAST_IDX) begin
        valid_q <= 1'b0;
        exh_q   <= 1'b1;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  // Data is a mux off the index, so it cannot move while a beat is stalled.
  // Gated with valid so the bus reads 0 outside a transfer.
  assign data_o      = valid_q ? coef_i[idx_q] : '0;
  assign valid_o     = valid_q;
  assign exhausted_o = exh_q;

endmodule

// File: rtl/iir_tap_loader.sv
// Configuration-side driver for the IIR filter tap-programming interface.
// Keeps shadow b/a coefficient sets and, on commit, flushes the filter by
// dropping its enable, re-enables it and streams both sets concurrently.
//   clk, reset_n                 : clock, async active-low reset (sync release)
//   cfg_wr_en/addr/data          : shadow write port (b[i] at i, a[i] at G_DEGREE+i)
//   cfg_commit                   : load the shadow set into the filter
//   cfg_wr_err                   : one-cycle pulse on a rejected write/commit
//   busy, loaded                 : sequence running / filter holds committed set
//   filt_enable                  : filter enable
//   b_tap*, a_tap*               : tap channels to the filter, *_done from filter
//
// state        | meaning
// ST_IDLE      | shadow writes accepted, waiting for commit
// ST_FLUSH     | filt_enable held low to clear filter history
// ST_STREAM    | b and a taps streaming concurrently
// ST_WAIT_DONE | all beats sent, waiting for both done flags
module iir_tap_loader
  import iir_pkg::*;
#(
  parameter int G_DEGREE       = 3,
  parameter int G_FLUSH_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(2*G_DEGREE)-1:0] cfg_wr_addr,
  input  float_t                        cfg_wr_data,
  input  logic                          cfg_commit,
  output logic                          cfg_wr_err,
  output logic                          busy,
  output logic                          loaded,
  output logic                          filt_enable,
  output float_t                        b_tap,
  output logic                          b_tap_valid,
  input  logic                          b_tap_ready,
  input  logic                          b_tap_done,
  output float_t                        a_tap,
  output logic                          a_tap_valid,
  input  logic                          a_tap_ready,
  input  logic                          a_tap_done
);

  localparam int NTAPS = 2 * G_DEGREE;
  localparam int FW    = (G_FLUSH_CYCLES > 1) ? $clog2(G_FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(G_FLUSH_CYCLES - 1);

  // Reset asserts asynchronously; release is re-timed to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];

  loader_state_e             state_q, state_d;
  logic [FW-1:0]             flush_cnt_q, flush_cnt_d;
  logic                      busy_q, busy_d;
  logic                      loaded_q, loaded_d;
  logic                      filt_en_q, filt_en_d;
  logic                      err_q, err_d;
  float_t [NTAPS-1:0]        shadow_q, shadow_d;
  logic                      ch_start;
  logic                      b_exh, a_exh;
  logic                      addr_ok;

  assign addr_ok = int'(cfg_wr_addr) < NTAPS;

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
      filt_en_q   <= 1'b0;
      err_q       <= 1'b0;
      shadow_q    <= '0;
      shadow_q[0] <= FP_ONE;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      loaded_q    <= loaded_d;
      filt_en_q   <= filt_en_d;
      err_q       <= err_d;
      shadow_q    <= shadow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    busy_d      = busy_q;
    loaded_d    = loaded_q;
    filt_en_d   = filt_en_q;
    shadow_d    = shadow_q;
    ch_start    = 1'b0;
    err_d       = (cfg_wr_en && (busy_q || !addr_ok)) || (cfg_commit && busy_q);

    case (state_q)
      ST_IDLE: begin
        // A write in the commit cycle lands in the same edge, so it is part
        // of the set that gets streamed.
        if (cfg_wr_en && addr_ok) shadow_d[cfg_wr_addr] = cfg_wr_data;
        if (cfg_commit) begin
          state_d     = ST_FLUSH;
          busy_d      = 1'b1;
          loaded_d    = 1'b0;
          filt_en_d   = 1'b0;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d   = ST_STREAM;
          filt_en_d = 1'b1;
          ch_start  = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
      ST_STREAM: begin
        if (b_exh && a_exh) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Done flags are only trusted here, after every beat has handshaken.
        if (b_tap_done && a_tap_done) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          loaded_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  iir_tap_stream_ch #(.G_DEGREE(G_DEGREE)) u_b_ch (
    .clk_i       (clk),
    .rst_n_i     (rst_n_s),
    .start_i     (ch_start),
    .coef_i      (shadow_q[G_DEGREE-1:0]),
    .ready_i     (b_tap_ready),
    .data_o      (b_tap),
    .valid_o     (b_tap_valid),
    .exhausted_o (b_exh)
  );

  iir_tap_stream_ch #(.G_DEGREE(G_DEGREE)) u_a_ch (
    .clk_i       (clk),
    .rst_n_i     (rst_n_s),
    .start_i     (ch_start),
    .coef_i      (shadow_q[NTAPS-1:G_DEGREE]),
    .ready_i     (a_tap_ready),
    .data_o      (a_tap),
    .valid_o     (a_tap_valid),
    .exhausted_o (a_exh)
  );

  assign cfg_wr_err  = err_q;
  assign busy        = busy_q;
  assign loaded      = loaded_q;
  assign filt_enable = filt_en_q;

endmodule

// File: tb/tb_iir_tap_loader.sv
module tb_iir_tap_loader;

  localparam int DEG   = 3;
  localparam int FLUSH = 2;
  localparam int NT    = 2 * DEG;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_wr_addr = '0;
  logic [31:0] cfg_wr_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_wr_err, busy, loaded, filt_enable;
  logic [31:0] b_tap, a_tap;
  logic        b_tap_valid, a_tap_valid;
  logic        b_tap_ready = 1'b0, a_tap_ready = 1'b0;
  logic        b_tap_done = 1'b0, a_tap_done = 1'b0;

  iir_tap_loader #(.G_DEGREE(DEG), .G_FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit), .cfg_wr_err(cfg_wr_err),
    .busy(busy), .loaded(loaded), .filt_enable(filt_enable),
    .b_tap(b_tap), .b_tap_valid(b_tap_valid), .b_tap_ready(b_tap_ready), .b_tap_done(b_tap_done),
    .a_tap(a_tap), .a_tap_valid(a_tap_valid), .a_tap_ready(a_tap_ready), .a_tap_done(a_tap_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: shadow contents as the register map defines them.
  logic [31:0] m_sh [NT];
  bit          tb_busy = 0;

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_sh[i] = 32'h0;
    m_sh[0] = 32'h3F80_0000;
  endtask

  task automatic model_wr(input logic [2:0] addr, input logic [31:0] data);
    if (!tb_busy && int'(addr) < NT) m_sh[addr] = data;
  endtask

  // Filter-side model: ready policy, beat capture, done flags.
  int          ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
  bit          force_done = 0;
  logic [31:0] b_got[$], a_got[$];
  int          b_vcyc = 0, a_vcyc = 0, err_cnt = 0;
  bit          b_stall = 0, a_stall = 0;
  logic [31:0] b_hold = '0, a_hold = '0;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       begin b_tap_ready = 1'b1; a_tap_ready = 1'b1; end
      1:       begin b_tap_ready = 1'($urandom_range(0, 1)); a_tap_ready = 1'($urandom_range(0, 1)); end
      default: begin b_tap_ready = 1'b0; a_tap_ready = 1'b0; end
    endcase
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      b_stall = 0;
      a_stall = 0;
    end else begin
      if (b_stall) begin
        check("b_hold_valid", 32'(b_tap_valid), 32'd1);
        check("b_hold_data", b_tap, b_hold);
      end
      if (a_stall) begin
        check("a_hold_valid", 32'(a_tap_valid), 32'd1);
        check("a_hold_data", a_tap, a_hold);
      end
      if (b_tap_valid) b_vcyc++;
      if (a_tap_valid) a_vcyc++;
      if (b_tap_valid && b_tap_ready) b_got.push_back(b_tap);
      if (a_tap_valid && a_tap_ready) a_got.push_back(a_tap);
      b_stall = b_tap_valid && !b_tap_ready;
      a_stall = a_tap_valid && !a_tap_ready;
      b_hold  = b_tap;
      a_hold  = a_tap;
      if (cfg_wr_err) err_cnt++;
    end
    b_tap_done = force_done || (b_got.size() >= DEG);
    a_tap_done = force_done || (a_got.size() >= DEG);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    cfg_wr_en = 1'b1; cfg_wr_addr = addr; cfg_wr_data = data;
    model_wr(addr, data);
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic start_commit(input bit with_wr, input logic [2:0] addr, input logic [31:0] data);
    int n;
    err_cnt = 0; b_vcyc = 0; a_vcyc = 0;
    b_got.delete(); a_got.delete();
    cfg_commit = 1'b1;
    if (with_wr) begin
      cfg_wr_en = 1'b1; cfg_wr_addr = addr; cfg_wr_data = data;
      model_wr(addr, data);
    end
    tick();
    cfg_commit = 1'b0; cfg_wr_en = 1'b0; tb_busy = 1;
    check("commit_busy", 32'(busy), 32'd1);
    check("commit_loaded", 32'(loaded), 32'd0);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (filt_enable) break;
      n++;
    end
    check("flush_len", 32'(n), 32'(FLUSH));
  endtask

  task automatic finish_commit(input int exp_err, input bit chk_thru);
    bit ok = 0;
    bit dropped = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (loaded) begin ok = 1; break; end
      if (!busy) dropped = 1;
    end
    tb_busy = 0;
    repeat (3) tick();
    check("load_done", 32'(ok), 32'd1);
    check("busy_hold", 32'(dropped), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_loaded", 32'(loaded), 32'd1);
    check("idle_filt_en", 32'(filt_enable), 32'd1);
    check("b_beats", 32'(b_got.size()), 32'(DEG));
    check("a_beats", 32'(a_got.size()), 32'(DEG));
    for (int i = 0; i < DEG; i++) begin
      check("b_data", (i < b_got.size()) ? b_got[i] : 32'hxxxx_xxxx, m_sh[i]);
      check("a_data", (i < a_got.size()) ? a_got[i] : 32'hxxxx_xxxx, m_sh[DEG + i]);
    end
    check("err_pulses", 32'(err_cnt), 32'(exp_err));
    if (chk_thru) begin
      check("b_valid_cycles", 32'(b_vcyc), 32'(DEG));
      check("a_valid_cycles", 32'(a_vcyc), 32'(DEG));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({filt_enable, busy, loaded, cfg_wr_err, b_tap_valid, a_tap_valid}), 32'd0);
    check({tag, "_b_tap"}, b_tap, 32'd0);
    check({tag, "_a_tap"}, a_tap, 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check_all_zero("post_reset");

    // Default set, full-rate sink.
    ready_mode = 0;
    start_commit(0, 3'd0, 32'd0);
    finish_commit(0, 1);

    // Directed set.
    wr(3'd0, 32'h3F00_0000); wr(3'd1, 32'h3E80_0000); wr(3'd2, 32'h0000_0000);
    wr(3'd3, 32'h3F80_0000); wr(3'd4, 32'hBF00_0000); wr(3'd5, 32'h3E80_0000);
    start_commit(0, 3'd0, 32'd0);
    finish_commit(0, 1);

    // Random sets under random backpressure; some rounds with early done and
    // a write folded into the commit cycle.
    for (int r = 0; r < 5; r++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) wr(3'($urandom_range(0, NT - 1)), $urandom);
      ready_mode = 1;
      force_done = r[0];
      start_commit(r >= 2, 3'($urandom_range(0, NT - 1)), $urandom);
      finish_commit(0, 0);
      force_done = 0;
    end

    // Write and commit while busy: both rejected, set unchanged.
    ready_mode = 2;
    start_commit(0, 3'd0, 32'd0);
    wr(3'd1, 32'hDEAD_BEEF);
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    ready_mode = 1;
    finish_commit(2, 0);
    ready_mode = 0;
    start_commit(0, 3'd0, 32'd0);
    finish_commit(0, 1);

    // Out-of-range addresses.
    err_cnt = 0;
    wr(3'd6, 32'h1234_5678);
    tick();
    wr(3'd7, 32'h8765_4321);
    repeat (3) tick();
    check("bad_addr_err", 32'(err_cnt), 32'd2);
    start_commit(0, 3'd0, 32'd0);
    finish_commit(0, 1);

    // Reset in the middle of streaming.
    ready_mode = 2;
    start_commit(0, 3'd0, 32'd0);
    repeat (2) tick();
    reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    model_reset();
    tb_busy = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    ready_mode = 0;
    start_commit(0, 3'd0, 32'd0);
    finish_commit(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
